// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_if
// Description : Receive-side handshake bundle for uart_rx. The master drives
//               the received byte and its valid flag; the slave (consumer)
//               answers with ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 16x oversampling UART receiver with a valid/ready output
//               holding register, framing-error and overrun-error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_BITS = 8
) (
    input  wire        clk,
    input  wire        rst_n,
    input  wire        rx_in,
    input  wire [15:0] baud_div,
    uart_rx_if.master  rx_bus,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun_err
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    localparam logic [2:0] c_LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic [3:0] c_MID_TICK = 4'd7;
    localparam logic [3:0] c_END_TICK = 4'd15;

    state_t               r_state;
    logic [15:0]          r_baud_div;
    logic [15:0]          r_div_cnt;
    logic [3:0]           r_tick_cnt;
    logic [2:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;

    logic                 w_tick;
    logic                 w_bit_end;
    logic                 w_done;
    logic [7:0]           w_data_ext;

    // The divider uses the rate latched at start detection, so the live
    // baud_div input cannot disturb a frame in flight.
    assign w_tick    = (r_div_cnt == r_baud_div);
    assign w_bit_end = w_tick && (r_tick_cnt == c_END_TICK);
    assign w_done    = (r_state == ST_STOP) && w_bit_end && rx_in;
    assign rx_busy   = (r_state != ST_IDLE);

    // Zero-extend the assembled frame to the 8-bit output bus.
    always_comb begin
        w_data_ext                  = '0;
        w_data_ext[DATA_BITS-1:0]   = r_shift;
    end

    // Oversample tick divider: held at zero while idle, restarts every tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if ((r_state == ST_IDLE) || w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 16'd1;
        end
    end

    // Receive FSM: start qualification at mid-bit, LSB-first data capture,
    // stop-bit check and recovery from a stuck-low line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_baud_div <= '0;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tick_cnt <= '0;
                    r_bit_cnt  <= '0;
                    if (!rx_in) begin
                        r_baud_div <= baud_div;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (r_tick_cnt == c_MID_TICK) begin
                            r_tick_cnt <= '0;
                            r_state    <= rx_in ? ST_IDLE : ST_DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        // 4-bit counter wraps to 0 after the 16th tick
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                        if (r_tick_cnt == c_END_TICK) begin
                            if (DATA_BITS > 1) begin
                                r_shift <= {rx_in, r_shift[DATA_BITS-1:1]};
                            end else begin
                                r_shift <= rx_in;
                            end
                            if (r_bit_cnt == c_LAST_BIT) begin
                                r_bit_cnt <= '0;
                                r_state   <= ST_STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_tick_cnt <= r_tick_cnt + 4'd1;
                        if (r_tick_cnt == c_END_TICK) begin
                            if (rx_in) begin
                                r_state <= ST_IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                r_state   <= ST_WAIT_HIGH;
                            end
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_in) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output holding register: a completed byte is loaded when the register
    // is free or being emptied this cycle; otherwise it is dropped and an
    // overrun is flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_bus.rx_data  <= '0;
            rx_bus.rx_valid <= 1'b0;
            overrun_err     <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (rx_bus.rx_valid && rx_bus.rx_ready) begin
                rx_bus.rx_valid <= w_done;
                if (w_done) begin
                    rx_bus.rx_data <= w_data_ext;
                end
            end else if (w_done) begin
                if (rx_bus.rx_valid) begin
                    overrun_err <= 1'b1;
                end else begin
                    rx_bus.rx_data  <= w_data_ext;
                    rx_bus.rx_valid <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx: table of frames plus hand
//               sequences for false start, stuck-low stop, overrun,
//               mid-frame reset and a 7-bit instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_in;
    logic        rx_in7;
    logic [15:0] baud_div;
    logic        busy, ferr, ovr;
    logic        busy7, ferr7, ovr7;

    uart_rx_if u_if ();
    uart_rx_if u_if7 ();

    uart_rx #(.DATA_BITS(8)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_in       (rx_in),
        .baud_div    (baud_div),
        .rx_bus      (u_if),
        .rx_busy     (busy),
        .frame_err   (ferr),
        .overrun_err (ovr)
    );

    uart_rx #(.DATA_BITS(7)) u_dut7 (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_in       (rx_in7),
        .baud_div    (baud_div),
        .rx_bus      (u_if7),
        .rx_busy     (busy7),
        .frame_err   (ferr7),
        .overrun_err (ovr7)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_ferr   = 0;
    int         n_ovr    = 0;
    logic       saw_both = 1'b0;
    logic [7:0] sb[$];

    // Pulse counters for the error outputs of the 8-bit instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ferr) n_ferr <= n_ferr + 1;
            if (ovr)  n_ovr  <= n_ovr + 1;
            if (ferr && ovr) saw_both <= 1'b1;
        end
    end

    typedef struct {
        logic [7:0]  data;
        int          bd;
        logic        stop;
        logic        scr;
        logic        exp_valid;
        logic [31:0] exp_ferr;
    } vec_t;

    vec_t vt[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_line(input bit to7, input logic v);
        if (to7) rx_in7 = v;
        else     rx_in  = v;
    endtask

    // Compare the byte being handed over with the oldest expected byte.
    task automatic pop_check();
        logic [7:0] e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow: got 0x%0h, expected no byte", u_if.rx_data);
        end else begin
            e = sb.pop_front();
            check("sb_data", u_if.rx_data, e);
        end
    endtask

    task automatic do_handshake();
        u_if.rx_ready = 1'b1;
        @(negedge clk);
        if (u_if.rx_valid) begin
            pop_check();
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake_valid: got 0, expected 1");
        end
        step();
        u_if.rx_ready = 1'b0;
    endtask

    // Drive one frame. Line is left low afterwards when the stop bit is 0.
    task automatic send_frame(input logic [7:0] d, input int nbits, input logic stop,
                              input int bd, input bit to7, input bit rdy_at_done,
                              input bit scr, input int stop_len);
        int p;
        p = 16 * (bd + 1);
        baud_div = 16'(bd);
        set_line(to7, 1'b0);
        for (int c = 0; c < p; c++) begin
            step();
            if (scr && c == 0) baud_div = 16'(bd + 5);
        end
        for (int i = 0; i < nbits; i++) begin
            set_line(to7, d[i]);
            repeat (p) step();
        end
        set_line(to7, stop);
        for (int c = 0; c < p * stop_len; c++) begin
            step();
            if (rdy_at_done && c == 8 * (bd + 1) - 1) begin
                u_if.rx_ready = 1'b1;
                @(negedge clk);
                if (u_if.rx_valid) begin
                    pop_check();
                end else begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done_handshake_valid: got 0, expected 1");
                end
            end
            if (rdy_at_done && c == 8 * (bd + 1)) u_if.rx_ready = 1'b0;
        end
        if (stop) set_line(to7, 1'b1);
        baud_div = 16'(bd);
    endtask

    initial begin
        int         f0, o0;
        logic [7:0] d7;

        vt[0] = '{8'hA5, 0, 1'b1, 1'b0, 1'b1, 32'd0};
        vt[1] = '{8'h00, 1, 1'b1, 1'b1, 1'b1, 32'd0};
        vt[2] = '{8'hFF, 2, 1'b1, 1'b0, 1'b1, 32'd0};
        vt[3] = '{8'h3C, 0, 1'b0, 1'b0, 1'b0, 32'd1};
        vt[4] = '{8'h81, 3, 1'b1, 1'b1, 1'b1, 32'd0};
        vt[5] = '{8'h5A, 1, 1'b1, 1'b0, 1'b1, 32'd0};

        rst_n          = 1'b0;
        rx_in          = 1'b1;
        rx_in7         = 1'b1;
        baud_div       = 16'd0;
        u_if.rx_ready  = 1'b0;
        u_if7.rx_ready = 1'b0;
        repeat (3) step();
        check("reset_outputs", {u_if.rx_data, u_if.rx_valid, busy, ferr, ovr}, 32'd0);
        check("reset_outputs7", {u_if7.rx_data, u_if7.rx_valid, busy7, ferr7, ovr7}, 32'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // Table-driven frames on the 8-bit instance
        for (int i = 0; i < 6; i++) begin
            f0 = n_ferr;
            if (vt[i].exp_valid) sb.push_back(vt[i].data);
            send_frame(vt[i].data, 8, vt[i].stop, vt[i].bd, 1'b0, 1'b0, vt[i].scr, 1);
            rx_in = 1'b1;
            repeat (4) step();
            check("vec_ferr", n_ferr - f0, vt[i].exp_ferr);
            check("vec_valid", u_if.rx_valid, vt[i].exp_valid);
            if (vt[i].exp_valid) begin
                do_handshake();
                check("vec_valid_clear", u_if.rx_valid, 32'd0);
            end
            check("vec_busy_idle", busy, 32'd0);
        end

        // False start: 16-clk glitch at baud_div=3
        f0 = n_ferr; o0 = n_ovr;
        baud_div = 16'd3;
        rx_in = 1'b0;
        repeat (16) step();
        rx_in = 1'b1;
        check("glitch_busy", busy, 32'd1);
        repeat (40) step();
        check("glitch_busy_end", busy, 32'd0);
        check("glitch_valid", u_if.rx_valid, 32'd0);
        check("glitch_errs", (n_ferr - f0) + (n_ovr - o0), 32'd0);

        // Stop bit held low for 40 bit times
        f0 = n_ferr;
        send_frame(8'h3C, 8, 1'b0, 0, 1'b0, 1'b0, 1'b0, 40);
        check("stuck_ferr_count", n_ferr - f0, 32'd1);
        check("stuck_valid", u_if.rx_valid, 32'd0);
        check("stuck_busy", busy, 32'd1);
        rx_in = 1'b1;
        repeat (2) step();
        check("stuck_busy_end", busy, 32'd0);

        // Back-to-back with no consumer: second byte dropped
        o0 = n_ovr;
        sb.push_back(8'h11);
        send_frame(8'h11, 8, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1);
        send_frame(8'h22, 8, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1);
        repeat (4) step();
        check("overrun_count", n_ovr - o0, 32'd1);
        check("overrun_valid", u_if.rx_valid, 32'd1);
        check("overrun_data", u_if.rx_data, 32'h11);
        do_handshake();

        // Back-to-back with handshake exactly on the completion cycle
        o0 = n_ovr;
        sb.push_back(8'h11);
        sb.push_back(8'h22);
        send_frame(8'h11, 8, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1);
        send_frame(8'h22, 8, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1);
        repeat (4) step();
        check("coincide_no_overrun", n_ovr - o0, 32'd0);
        check("coincide_valid", u_if.rx_valid, 32'd1);
        check("coincide_data", u_if.rx_data, 32'h22);
        do_handshake();

        // Leave a byte in the holding register, then reset mid-frame
        sb.push_back(8'hC3);
        send_frame(8'hC3, 8, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1);
        repeat (4) step();
        check("pre_reset_valid", u_if.rx_valid, 32'd1);
        rx_in = 1'b0;
        repeat (16) step();
        rx_in = 1'b1;
        repeat (40) step();
        check("mid_frame_busy", busy, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {u_if.rx_data, u_if.rx_valid, busy, ferr, ovr}, 32'd0);
        void'(sb.pop_back());
        step();
        rst_n = 1'b1;
        f0 = n_ferr; o0 = n_ovr;
        repeat (200) step();
        check("post_reset_idle", {u_if.rx_valid, busy}, 32'd0);
        check("post_reset_errs", (n_ferr - f0) + (n_ovr - o0), 32'd0);
        sb.push_back(8'h5A);
        send_frame(8'h5A, 8, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1);
        repeat (4) step();
        check("post_reset_valid", u_if.rx_valid, 32'd1);
        do_handshake();

        // 7-bit instance
        send_frame(8'h55, 7, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1);
        repeat (4) step();
        check("bits7_valid", u_if7.rx_valid, 32'd1);
        check("bits7_data", u_if7.rx_data, 32'h55);
        d7 = u_if7.rx_data;
        check("bits7_msb", d7[7], 32'd0);
        check("bits7_ferr", ferr7, 32'd0);
        u_if7.rx_ready = 1'b1;
        step();
        u_if7.rx_ready = 1'b0;
        check("bits7_valid_clear", u_if7.rx_valid, 32'd0);

        check("errors_exclusive", saw_both, 32'd0);
        check("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
